path_delay_monitor: RTL and testbench



---
 rtl/path_delay_monitor.sv | 172 +++++++++++++++++
 tb/tb_path_delay_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/path_delay_monitor.sv
// Launch/capture monitor: toggles the drive into a path under test, times the
// synchronized response in clock cycles and flags out-of-tolerance, timeout or stuck paths.
module path_delay_monitor #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SETTLE      = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit INVERT      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] ref_cnt,
    input  logic [CNT_W-1:0] tol,
    output logic             path_in,
    input  logic             path_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] delay_cnt,
    output logic             timeout,
    output logic             stuck,
    output logic             alarm
);

    typedef enum logic [1:0] {IDLE, PREP, MEASURE, DONE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LAST_C = CNT_W'(SETTLE - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       ref_q, ref_d;
    logic [CNT_W-1:0]       tol_q, tol_d;
    logic [CNT_W-1:0]       delay_q, delay_d;
    logic                   path_in_q, path_in_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   stuck_q, stuck_d;
    logic                   alarm_q, alarm_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic             s_out;
    logic             level_ok;
    logic [CNT_W-1:0] meas;
    logic [CNT_W:0]   upper_lim;
    logic [CNT_W:0]   meas_plus_tol;
    logic             out_of_tol;

    // path_out is asynchronous to clk, so it crosses a plain flop chain first
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q[gi] <= 1'b0;
            end else if (gi == 0) begin
                sync_q[gi] <= path_out;
            end else begin
                sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi-1];
            end
        end
    end

    assign s_out    = sync_q[SYNC_STAGES-1];
    assign level_ok = (s_out == (path_in_q ^ INVERT));

    // One extra bit on both sums so ref+tol and delay+tol never wrap
    assign meas          = level_ok ? cnt_q : TIMEOUT_C;
    assign upper_lim     = {1'b0, ref_q} + {1'b0, tol_q};
    assign meas_plus_tol = {1'b0, meas} + {1'b0, tol_q};
    assign out_of_tol    = ({1'b0, meas} > upper_lim) || (meas_plus_tol < {1'b0, ref_q});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        tol_d     = tol_q;
        delay_d   = delay_q;
        path_in_d = path_in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        stuck_d   = stuck_q;
        alarm_d   = alarm_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ref_d   = ref_cnt;
                    tol_d   = tol;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (cnt_q == SETTLE_LAST_C) begin
                    if (!level_ok) begin
                        stuck_d   = 1'b1;
                        timeout_d = 1'b0;
                        alarm_d   = 1'b1;
                        delay_d   = '0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = DONE;
                    end else begin
                        path_in_d = ~path_in_q;
                        cnt_d     = '0;
                        state_d   = MEASURE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                // cnt_q already holds the cycles elapsed since launch, excluding this one
                if (level_ok || (cnt_q == TIMEOUT_C)) begin
                    delay_d   = meas;
                    timeout_d = !level_ok;
                    stuck_d   = 1'b0;
                    alarm_d   = !level_ok || out_of_tol;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ref_q     <= '0;
            tol_q     <= '0;
            delay_q   <= '0;
            path_in_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            stuck_q   <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            tol_q     <= tol_d;
            delay_q   <= delay_d;
            path_in_q <= path_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            stuck_q   <= stuck_d;
            alarm_q   <= alarm_d;
        end
    end

    assign path_in   = path_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign delay_cnt = delay_q;
    assign timeout   = timeout_q;
    assign stuck     = stuck_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_path_delay_monitor.sv
// Scoreboard bench for path_delay_monitor: a modelled path (loopback, N-cycle delay,
// frozen output, wrong level) feeds path_out; expected results are queued at each start.
module tb_path_delay_monitor;

    localparam int CW = 16;
    localparam int TO = 50;
    localparam int ST = 4;
    localparam int SY = 2;

    typedef struct {
        int done_cyc;
        int dly;
        int to;
        int st;
        int al;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] ref_cnt = '0;
    logic [CW-1:0] tol = '0;
    logic          path_in;
    logic          path_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] delay_cnt;
    logic          timeout;
    logic          stuck;
    logic          alarm;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   tog = 0;
    logic pi_prev = 1'b0;
    logic [7:0] dl = '0;
    int   mode = 0;
    int   dpath = 0;
    logic hold_val = 1'b0;
    exp_t sb[$];

    path_delay_monitor #(
        .CNT_W(CW), .TIMEOUT(TO), .SETTLE(ST), .SYNC_STAGES(SY), .INVERT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ref_cnt(ref_cnt), .tol(tol),
        .path_in(path_in), .path_out(path_out), .busy(busy), .done(done),
        .delay_cnt(delay_cnt), .timeout(timeout), .stuck(stuck), .alarm(alarm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dl  <= {dl[6:0], path_in};
    end

    // mode 0: inverting path of dpath whole cycles; 1: frozen output; 2: wrong steady level
    always_comb begin
        path_out = path_in;
        case (mode)
            0:       path_out = ((dpath == 0) ? path_in : dl[dpath-1]) ^ 1'b1;
            1:       path_out = hold_val;
            default: path_out = path_in;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (path_in !== pi_prev) tog++;
            pi_prev = path_in;
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    $display("done @%0d: delay=%0d timeout=%0b stuck=%0b alarm=%0b",
                             cyc, delay_cnt, timeout, stuck, alarm);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("delay_cnt", delay_cnt, e.dly);
                    chk("timeout", timeout, e.to);
                    chk("stuck", stuck, e.st);
                    chk("alarm", alarm, e.al);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    task automatic run(input int m, input int d, input int r, input int t, input bit poke);
        exp_t e;
        int s, nd0, t0, guard;
        @(negedge clk);
        mode  = m;
        dpath = d;
        if (m == 1) hold_val = path_in ^ 1'b1;
        ref_cnt = CW'(r);
        tol     = CW'(t);
        start   = 1'b1;
        s = cyc + 1;
        e.to = 0; e.st = 0;
        if (m == 2) begin
            e.st = 1; e.dly = 0; e.al = 1; e.done_cyc = s + ST;
        end else if (m == 1) begin
            e.to = 1; e.dly = TO; e.al = 1; e.done_cyc = s + ST + TO + 1;
        end else begin
            e.dly = d + SY;
            e.al  = ((e.dly > r + t) || (e.dly + t < r)) ? 1 : 0;
            e.done_cyc = s + ST + e.dly + 1;
        end
        sb.push_back(e);
        t0  = tog;
        nd0 = n_done;
        $display("start @%0d: mode=%0d delay=%0d ref=%0d tol=%0d", s, m, d, r, t);
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (ST + 1) @(negedge clk);
            chk("busy_when_poked", busy, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        guard = 0;
        while (n_done == nd0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (n_done == nd0) begin
            chk("done_wait", 0, 1);
            void'(sb.pop_front());
        end
        repeat (3) @(negedge clk);
        chk("launch_count", tog - t0, (m == 2) ? 0 : 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_path_in", path_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_delay", delay_cnt, 0);
        chk("rst_flags", {timeout, stuck, alarm}, 0);
        rst = 1'b0;

        run(0, 0, 2, 0, 1'b0);
        chk("rising_launch", path_in, 1);
        run(0, 0, 2, 0, 1'b0);
        chk("falling_launch", path_in, 0);
        run(0, 0, 5, 2, 1'b0);
        run(0, 0, 5, 3, 1'b0);
        run(0, 5, 2, 4, 1'b0);
        run(0, 5, 2, 5, 1'b0);
        run(0, 5, 7, 0, 1'b1);
        run(1, 0, 7, 0, 1'b0);
        run(2, 0, 0, 0, 1'b0);
        run(0, 0, 2, 0, 1'b0);

        // abort a measurement with reset; no result may follow
        @(negedge clk);
        mode = 0; dpath = 5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ST + 2) @(negedge clk);
        chk("busy_mid_measure", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_path_in", path_in, 0);
        chk("abort_busy", busy, 0);
        chk("abort_delay", delay_cnt, 0);
        chk("abort_flags", {done, timeout, stuck, alarm}, 0);
        repeat (15) @(negedge clk);
        run(0, 0, 2, 0, 1'b0);
        chk("post_abort_rising", path_in, 1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
